// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, sync/blank bundle type and porch helpers
package vga_pkg;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BACK   = 48;
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FRONT  = 16;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BACK   = 33;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FRONT  = 10;
    localparam int VGA640_HS_POL   = 0;
    localparam int VGA640_VS_POL   = 0;

    // 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs
    localparam int VGA800_H_SYNC   = 128;
    localparam int VGA800_H_BACK   = 88;
    localparam int VGA800_H_ACTIVE = 800;
    localparam int VGA800_H_FRONT  = 40;
    localparam int VGA800_V_SYNC   = 4;
    localparam int VGA800_V_BACK   = 23;
    localparam int VGA800_V_ACTIVE = 600;
    localparam int VGA800_V_FRONT  = 1;
    localparam int VGA800_HS_POL   = 1;
    localparam int VGA800_VS_POL   = 1;

    // Raw (undelayed) or delayed control bundle; all-zero means no sync, blanked
    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } vga_ctrl_t;

    // Ticks (or lines) in one complete period of a dimension
    function automatic int vga_total(input int sync, input int back, input int active, input int front);
        return sync + back + active + front;
    endfunction

    // Counter value of the first visible column (or row)
    function automatic int vga_active_start(input int sync, input int back);
        return sync + back;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - enabled shift register with synchronous clear, zero depth is a wire
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        // No stages: the clock side is intentionally left idle
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, en};
        assign dout = din;
    end else begin : g_pipe
        logic [DEPTH-1:0][WIDTH-1:0] stage_q;
        logic [DEPTH-1:0][WIDTH-1:0] stage_d;

        // Shift one stage per enabled tick, otherwise hold
        always_comb begin
            stage_d = stage_q;
            if (en) begin
                stage_d[0] = din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end
        end

        // Clear to all-zero (inactive sync, blanked) on reset
        always_ff @(posedge clk) begin
            if (rst) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing and pixel stage; VGA_TEST_PATTERN_EN adds colour bars
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BACK   = VGA640_H_BACK,
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FRONT  = VGA640_H_FRONT,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BACK   = VGA640_V_BACK,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FRONT  = VGA640_V_FRONT,
    parameter int HS_POL   = VGA640_HS_POL,
    parameter int VS_POL   = VGA640_VS_POL,
    parameter int RD_LAT   = 0,
    parameter int COLOR_W  = 4,
    localparam int COL_W   = $clog2(H_ACTIVE),
    localparam int ROW_W   = $clog2(V_ACTIVE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                 test_en,
`endif
    input  logic [3*COLOR_W-1:0] data,
    output logic                 read,
    output logic [ROW_W-1:0]     row,
    output logic [COL_W-1:0]     column,
    output logic                 hsync,
    output logic                 vsync,
    output logic [COLOR_W-1:0]   r,
    output logic [COLOR_W-1:0]   g,
    output logic [COLOR_W-1:0]   b,
    output logic                 vblank,
    output logic                 frame_start
);

    localparam int H_TOTAL = vga_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
    localparam int V_TOTAL = vga_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);

    localparam logic [HC_W-1:0] H_LAST     = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_SYNC_END = HC_W'(H_SYNC);
    localparam logic [HC_W-1:0] H_START    = HC_W'(vga_active_start(H_SYNC, H_BACK));
    localparam logic [HC_W-1:0] H_ACT_LEN  = HC_W'(H_ACTIVE);
    localparam logic [VC_W-1:0] V_LAST     = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_SYNC_END = VC_W'(V_SYNC);
    localparam logic [VC_W-1:0] V_START    = VC_W'(vga_active_start(V_SYNC, V_BACK));
    localparam logic [VC_W-1:0] V_ACT_LEN  = VC_W'(V_ACTIVE);
    localparam logic            HS_LVL     = (HS_POL != 0);
    localparam logic            VS_LVL     = (VS_POL != 0);

    logic [HC_W-1:0] h_cnt_q, h_cnt_d;
    logic [VC_W-1:0] v_cnt_q, v_cnt_d;

    // Advance the raster position one pixel per enabled tick, line on h wrap
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + 1'b1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // Raster position registers; reset restarts at the top of the sync pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Offsets from the active start; the unsigned compare rejects both porches
    logic [HC_W-1:0] h_rel;
    logic [VC_W-1:0] v_rel;
    logic            h_act;
    logic            v_act;
    vga_ctrl_t       raw_ctrl;

    assign h_rel = h_cnt_q - H_START;
    assign v_rel = v_cnt_q - V_START;
    assign h_act = (h_cnt_q >= H_START) && (h_rel < H_ACT_LEN);
    assign v_act = (v_cnt_q >= V_START) && (v_rel < V_ACT_LEN);

    assign raw_ctrl.hs     = (h_cnt_q < H_SYNC_END);
    assign raw_ctrl.vs     = (v_cnt_q < V_SYNC_END);
    assign raw_ctrl.active = h_act && v_act;

    assign read        = raw_ctrl.active;
    assign column      = h_rel[COL_W-1:0];
    assign row         = v_rel[ROW_W-1:0];
    assign vblank      = ~v_act;
    assign frame_start = en && (h_cnt_q == H_START) && (v_cnt_q == V_START);

    // Sync and blank ride alongside the framebuffer read so they meet its data
`ifdef VGA_TEST_PATTERN_EN
    localparam int DL_W = 3 + COL_W;
    logic [DL_W-1:0] dl_in;
    assign dl_in = {raw_ctrl, column};
`else
    localparam int DL_W = 3;
    logic [DL_W-1:0] dl_in;
    assign dl_in = raw_ctrl;
`endif

    logic [DL_W-1:0] dl_out;
    vga_ctrl_t       dl_ctrl;

    vga_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (RD_LAT)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .din  (dl_in),
        .dout (dl_out)
    );

    assign dl_ctrl = vga_ctrl_t'(dl_out[DL_W-1 -: 3]);

`ifdef VGA_TEST_PATTERN_EN
    // Eight equal-width bars indexed by the delayed column
    localparam int BAR_W = H_ACTIVE / 8;
    logic [COL_W-1:0] dl_col;
    logic [COL_W-1:0] bar_idx;
    assign dl_col  = dl_out[COL_W-1:0];
    assign bar_idx = dl_col / COL_W'(BAR_W);
`endif

    logic [3*COLOR_W-1:0] pix;

    // Pixel mux: framebuffer data (or bars) while visible, black while blanked
    always_comb begin
        pix = '0;
        if (dl_ctrl.active) begin
            pix = data;
`ifdef VGA_TEST_PATTERN_EN
            if (test_en) begin
                pix = {{COLOR_W{bar_idx[2]}}, {COLOR_W{bar_idx[1]}}, {COLOR_W{bar_idx[0]}}};
            end
`endif
        end
    end

    assign r     = pix[3*COLOR_W-1 -: COLOR_W];
    assign g     = pix[2*COLOR_W-1 -: COLOR_W];
    assign b     = pix[COLOR_W-1:0];
    assign hsync = dl_ctrl.hs ? HS_LVL : ~HS_LVL;
    assign vsync = dl_ctrl.vs ? VS_LVL : ~VS_LVL;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen at read latency 0 and 2
module tb_vga_timing_gen;

    localparam int HS = 4, HB = 3, HA = 16, HF = 2, HT = 25;
    localparam int VS = 2, VB = 2, VA = 6, VF = 1, VT = 11;
    localparam logic HSP = 1'b0;
    localparam logic VSP = 1'b1;
    localparam int FS_DELAY = (VS + VB) * HT + HS + HB;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en;
    logic [11:0] data0, data2;
    logic read0, read2, hs0, hs2, vs0, vs2, vb0, vb2, fs0, fs2;
    logic [2:0] row0, row2;
    logic [3:0] col0, col2, r0, g0, b0, r2, g2, b2;
`ifdef VGA_TEST_PATTERN_EN
    logic test_en;
`endif

    vga_timing_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
        .HS_POL(0), .VS_POL(1), .RD_LAT(0), .COLOR_W(4)
    ) u_dut0 (
        .clk(clk), .rst(rst), .en(en),
`ifdef VGA_TEST_PATTERN_EN
        .test_en(test_en),
`endif
        .data(data0), .read(read0), .row(row0), .column(col0),
        .hsync(hs0), .vsync(vs0), .r(r0), .g(g0), .b(b0),
        .vblank(vb0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
        .HS_POL(0), .VS_POL(1), .RD_LAT(2), .COLOR_W(4)
    ) u_dut2 (
        .clk(clk), .rst(rst), .en(en),
`ifdef VGA_TEST_PATTERN_EN
        .test_en(test_en),
`endif
        .data(data2), .read(read2), .row(row2), .column(col2),
        .hsync(hs2), .vsync(vs2), .r(r2), .g(g2), .b(b2),
        .vblank(vb2), .frame_start(fs2)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   mh, mv;
    bit   tp;
    int   reads0;
    logic last_fs0;
    logic [11:0] dh [3];
    ent_t q0 [$];
    ent_t q2 [$];

    function automatic bit m_act(input int h, input int v);
        return (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
    endfunction

    // Framebuffer model: pattern word while read, nonzero garbage otherwise
    function automatic logic [11:0] m_word(input int h, input int v);
        if (m_act(h, v)) return {4'(h - HS - HB), 1'b0, 3'(v - VS - VB), 4'hA};
        return 12'h5A5;
    endfunction

    function automatic ent_t m_ent(input int h, input int v, input bit t);
        ent_t e;
        logic [2:0] k;
        e.hs  = (h < HS) ? HSP : ~HSP;
        e.vs  = (v < VS) ? VSP : ~VSP;
        e.rgb = 12'h000;
        k     = 3'((h - HS - HB) / (HA / 8));
        if (m_act(h, v)) begin
            if (t) e.rgb = {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
            else   e.rgb = m_word(h, v);
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at h=%0d v=%0d: observed=%0h expected=%0h", tag, mh, mv, obs, exp);
        end
    endtask

    task automatic model_reset();
        ent_t rst_e;
        rst_e.hs  = ~HSP;
        rst_e.vs  = ~VSP;
        rst_e.rgb = 12'h000;
        mh = 0;
        mv = 0;
        q0.delete();
        q2.delete();
        q0.push_back(m_ent(0, 0, tp));
        q2.push_back(rst_e);
        q2.push_back(rst_e);
        q2.push_back(m_ent(0, 0, tp));
        dh[0] = m_word(0, 0);
        dh[1] = 12'h5A5;
        dh[2] = 12'h5A5;
    endtask

    task automatic check_all(input bit en_v);
        bit exp_read, exp_vb, exp_fs;
        exp_read = m_act(mh, mv);
        exp_vb   = !((mv >= VS + VB) && (mv < VS + VB + VA));
        exp_fs   = en_v && (mh == HS + HB) && (mv == VS + VB);
        check("read0", 32'(read0), 32'(exp_read));
        check("read2", 32'(read2), 32'(exp_read));
        if (exp_read) begin
            check("column0", 32'(col0), 32'(mh - HS - HB));
            check("row0", 32'(row0), 32'(mv - VS - VB));
            check("column2", 32'(col2), 32'(mh - HS - HB));
            check("row2", 32'(row2), 32'(mv - VS - VB));
        end
        check("vblank0", 32'(vb0), 32'(exp_vb));
        check("vblank2", 32'(vb2), 32'(exp_vb));
        check("frame_start0", 32'(fs0), 32'(exp_fs));
        check("frame_start2", 32'(fs2), 32'(exp_fs));
        check("hsync0", 32'(hs0), 32'(q0[0].hs));
        check("vsync0", 32'(vs0), 32'(q0[0].vs));
        check("rgb0", 32'({r0, g0, b0}), 32'(q0[0].rgb));
        check("hsync2", 32'(hs2), 32'(q2[0].hs));
        check("vsync2", 32'(vs2), 32'(q2[0].vs));
        check("rgb2", 32'({r2, g2, b2}), 32'(q2[0].rgb));
        if (en_v && read0) reads0++;
        last_fs0 = fs0;
    endtask

    // One clock: drive, check settled outputs, clock, update model and memory data
    task automatic step(input bit en_v, input bit rst_v);
        en  = en_v;
        rst = rst_v;
        #1;
        if (!rst_v) check_all(en_v);
        @(posedge clk);
        if (rst_v) begin
            model_reset();
        end else if (en_v) begin
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            dh[2] = dh[1];
            dh[1] = dh[0];
            dh[0] = m_word(mh, mv);
            void'(q0.pop_front());
            void'(q2.pop_front());
            q0.push_back(m_ent(mh, mv, tp));
            q2.push_back(m_ent(mh, mv, tp));
        end
        #1;
        data0 = dh[0];
        data2 = dh[2];
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        en       = 1'b1;
        tp       = 1'b0;
        data0    = 12'h000;
        data2    = 12'h000;
        reads0   = 0;
        last_fs0 = 1'b0;
        mh       = 0;
        mv       = 0;
`ifdef VGA_TEST_PATTERN_EN
        test_en  = 1'b0;
`endif
        @(negedge clk);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        // Two full frames with en held high
        reads0 = 0;
        repeat (2 * HT * VT) step(1'b1, 1'b0);
        check("reads_per_two_frames", 32'(reads0), 32'(2 * HA * VA));

        // en on every second clock
        repeat (HT * VT) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end

        // Random en pattern
        repeat (400) step(1'($urandom_range(0, 1)), 1'b0);

        // Reset in the middle of a visible line
        for (int i = 0; i < 3 * HT * VT && !(mh == 12 && mv == 6); i++) step(1'b1, 1'b0);
        check("reached_reset_point", 32'(mh == 12 && mv == 6), 32'd1);
        step(1'b1, 1'b1);
        for (n = 0; n < 2 * HT * VT; n++) begin
            step(1'b1, 1'b0);
            if (last_fs0) break;
        end
        check("frame_start_after_reset", 32'(n), 32'(FS_DELAY));

`ifdef VGA_TEST_PATTERN_EN
        // One frame of colour bars, switched at a frame boundary
        for (int i = 0; i < 2 * HT * VT && !(mh == 0 && mv == 0); i++) step(1'b1, 1'b0);
        tp      = 1'b1;
        test_en = 1'b1;
        repeat (HT * VT) step(1'b1, 1'b0);
        tp      = 1'b0;
        test_en = 1'b0;
        repeat (HT) step(1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator and pixel output stage, successor to the fixed 640x480@60 port. It sits between the framebuffer read port and the board VGA pins. It generates sync, blanking and framebuffer read coordinates for any mode described by porch/sync parameters. It compensates a configurable framebuffer read latency so RGB stays aligned with sync, and adds a pixel-clock enable and frame/blanking status for the CPU side.

## Interface
- H_SYNC, 96, horizontal sync width (ticks)
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, visible columns
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2; V_BACK, 33; V_ACTIVE, 480; V_FRONT, 10, vertical equivalents (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- RD_LAT, 0, framebuffer read latency in pixel ticks (0..7)
- COLOR_W, 4, bits per colour channel
- Derived: H_TOTAL, V_TOTAL = sums; COL_W = $clog2(H_ACTIVE); ROW_W = $clog2(V_ACTIVE)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  pixel tick enable; all state advances only when en=1
- data  in  3*COLOR_W  framebuffer pixel {r,g,b}, valid RD_LAT ticks after read
- read  out  1  framebuffer read request (active region)
- row  out  ROW_W  active row; meaningful only while read=1
- column  out  COL_W  active column; meaningful only while read=1
- hsync, vsync  out  1  sync outputs, aligned to rgb
- r, g, b  out  COLOR_W each  pixel output, zero when blanked
- vblank  out  1  high while vertical counter is outside the active rows (undelayed)
- frame_start  out  1  one-tick pulse (qualified by en) on the first active pixel of a frame

## Operation
- h_cnt counts 0..H_TOTAL-1 on each tick and wraps to 0; v_cnt increments on h wrap and wraps 0 after V_TOTAL-1.
- Per-line region order: sync [0, H_SYNC), back porch, active [H_SYNC+H_BACK, +H_ACTIVE), front porch. Vertical regions use the same order.
- read = h active AND v active, combinational from the counters.
- column = h_cnt − (H_SYNC+H_BACK) and row = v_cnt − (V_SYNC+V_BACK), truncated to their widths.
- Raw hsync/vsync/active go through an RD_LAT-deep delay line that advances on en. Outputs take the delay line's last stage.
- rgb = delayed_active ? data : 0. hsync = delayed_hs ? HS_POL : ~HS_POL. vsync uses the same rule with VS_POL.
- RD_LAT=0 gives no delay stages; the behaviour is then cycle-identical to the legacy 640x480 port.
- frame_start = en AND h_cnt, v_cnt at the first active coordinate (undelayed, coincident with the read of pixel 0,0).

## Timing
- Reset values:
  - Counters 0, all delay stages cleared to inactive sync and blank.
  - Immediately after reset: rgb=0, hsync=~HS_POL, vsync=~VS_POL for RD_LAT ticks, then the counter-driven values appear.
  - read=0, vblank=1, frame_start=0.
- Latency: read→rgb is RD_LAT ticks. Sync and blank edges are shifted by RD_LAT ticks relative to the counters.
- en=0: counters, delay line and all registered outputs hold; frame_start=0.
- Reset mid-frame: on the next edge, counters go to (0,0) and the delay line is cleared. A fresh frame starts with no partial pulses.
- rst has priority over en.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - Adds input test_en (1 bit).
  - When test_en=1, rgb ignores data and shows 8 vertical bars. k = column/(H_ACTIVE/8), using the delayed column; each channel = all-ones if k[2] (r), k[1] (g), k[0] (b), else 0.
  - Blanking and sync are unchanged.
  - H_ACTIVE must be divisible by 8.
- Not defined: no test_en port, no bar logic.

## Structure
- Shared package vga_pkg holds the default timing constants for 640x480@60 and 800x600@60, and a function computing total/active-start from porch parameters.
- Sub-module vga_delay_line: parametric width/depth shift register with enable and synchronous clear. It carries {hs, vs, active} and, under the macro, column.

## Test plan
- Defaults, RD_LAT=0, en=1, after rst → hsync low for ticks 0..95 and high for 96..799; line period 800; vsync low for lines 0..1; frame 420000 ticks.
- Defaults → read first rises at h=144, v=35 with row=0, col=0 and frame_start=1 that tick; last read at h=783, v=514 with row=479, col=639; 307200 reads per frame.
- RD_LAT=2, model memory returns {col[3:0], row[3:0], 4'hA} two ticks after read → rgb nonzero exactly 2 ticks after read, matches the model; hsync falling edge at tick 2 of each line.
- en high every 2nd clk → all periods double; outputs constant on clocks with en=0.
- rst for one cycle at h=300, v=200 → next cycle counters (0,0) and rgb=0; frame_start arrives 35*800+144 ticks later.
- Macro defined, test_en=1 → column 0 → 000, column 80 → 00F, column 639 → FFF; rgb=0 in blanking.
